// File: rtl/matrix_pkg.sv
// Shared constants and state type for the 16x16 LED matrix frame path.
// Used by the frame loader, the scan driver and the benches.
package matrix_pkg;

  localparam int MAT_SIDE    = 16;
  localparam int MAT_BITS    = MAT_SIDE * MAT_SIDE;
  localparam int FRAME_BYTES = MAT_BITS / 8;
  localparam int COUNT_W     = $clog2(FRAME_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } loader_state_t;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter for the frame loader: counts enabled cycles and flags the
// cycle in which the LIMIT-th consecutive enabled cycle completes.
module loader_timeout #(
  parameter int LIMIT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  // Terminal fires while the counter sits at LIMIT-1, so the abort edge is
  // the LIMIT-th idle edge.
  assign terminal = enable && !clear && (cnt_reg == LAST);

  always_comb begin
    cnt_next = cnt_reg;
    if (clear || terminal) begin
      cnt_next = '0;
    end else if (enable) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/matrix_frame_loader.sv
// Byte-stream frame loader: assembles 32 bytes into a back buffer and commits
// it to mat on swap_ok. Optional idle abort under FRAME_LOADER_TIMEOUT_EN.
module matrix_frame_loader
  import matrix_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  input  logic               in_sof,
  output logic               in_ready,
  input  logic               swap_ok,
  output logic [0:MAT_BITS-1] mat,
  output logic               frame_done,
  output logic               frame_err
);

  localparam logic [COUNT_W-1:0] LAST_BYTE = COUNT_W'(FRAME_BYTES - 1);

  loader_state_t         state_reg, state_next;
  logic [COUNT_W-1:0]    count_reg, count_next;
  logic [0:MAT_BITS-1]   back_reg, back_next;
  logic [0:MAT_BITS-1]   mat_reg, mat_next;
  logic                  frame_done_reg, frame_done_next;
  logic                  frame_err_reg, frame_err_next;
  logic                  accept;
  logic                  timeout_hit;

  if (IDLE_TIMEOUT < 2) begin : g_bad_timeout
    $error("IDLE_TIMEOUT must be at least 2");
  end

  assign in_ready   = (state_reg != PEND);
  assign accept     = in_valid && in_ready;
  assign mat        = mat_reg;
  assign frame_done = frame_done_reg;
  assign frame_err  = frame_err_reg;

`ifdef FRAME_LOADER_TIMEOUT_EN
  loader_timeout #(
    .LIMIT (IDLE_TIMEOUT)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear    (accept || (state_reg != LOAD)),
    .enable   (state_reg == LOAD),
    .terminal (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    back_next       = back_reg;
    mat_next        = mat_reg;
    frame_done_next = 1'b0;
    frame_err_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept && in_sof) begin
          back_next[0 +: 8] = in_data;
          count_next        = COUNT_W'(1);
          state_next        = LOAD;
        end
      end
      LOAD: begin
        if (accept && in_sof) begin
          // Resync: the partial frame is abandoned and this byte restarts it.
          frame_err_next    = 1'b1;
          back_next[0 +: 8] = in_data;
          count_next        = COUNT_W'(1);
        end else if (accept) begin
          back_next[{count_reg, 3'b000} +: 8] = in_data;
          if (count_reg == LAST_BYTE) begin
            count_next = '0;
            state_next = PEND;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end else if (timeout_hit) begin
          frame_err_next = 1'b1;
          count_next     = '0;
          state_next     = IDLE;
        end
      end
      PEND: begin
        if (swap_ok) begin
          mat_next        = back_reg;
          frame_done_next = 1'b1;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      back_reg       <= '0;
      mat_reg        <= '0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      back_reg       <= back_next;
      mat_reg        <= mat_next;
      frame_done_reg <= frame_done_next;
      frame_err_reg  <= frame_err_next;
    end
  end

endmodule

// File: tb/tb_matrix_frame_loader.sv
// Directed bench for matrix_frame_loader; the idle-timeout step runs only when
// FRAME_LOADER_TIMEOUT_EN is defined.
module tb_matrix_frame_loader;
  import matrix_pkg::*;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [7:0]          in_data = 8'h00;
  logic                in_valid = 1'b0;
  logic                in_sof = 1'b0;
  logic                in_ready;
  logic                swap_ok = 1'b0;
  logic [0:MAT_BITS-1] mat;
  logic                frame_done;
  logic                frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_err = 0;
  int n_busy = 0;

  matrix_frame_loader #(.IDLE_TIMEOUT(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .swap_ok    (swap_ok),
    .mat        (mat),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (frame_done === 1'b1) n_done++;
    if (frame_err === 1'b1) n_err++;
    if (in_ready === 1'b0) n_busy++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-18s observed %h", tag, obs);
  endtask

  function automatic logic [7:0] pat(input int k);
    case (k)
      0: return 8'h20;
      1: return 8'h40;
      2: return 8'h28;
      3: return 8'hA0;
      default: return 8'((k * 13 + 5) & 8'hFF);
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic s);
    int guard;
    guard = 0;
    @(negedge clock);
    in_data  = d;
    in_sof   = s;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) check("ready_timeout", 256'(in_ready), 256'(1));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  logic [0:MAT_BITS-1] exp1, exp2, exp3, exp4, frame;
  int base_done, base_err, base_busy, first_err;

  initial begin
    for (int k = 0; k < FRAME_BYTES; k++) begin
      exp1[8*k +: 8] = pat(k);
      exp2[8*k +: 8] = ~pat(k);
      exp3[8*k +: 8] = 8'(k);
      exp4[8*k +: 8] = 8'(255 - k);
    end

    // Reset state
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_mat", 256'(mat), 256'(0));
    check("reset_ready", 256'(in_ready), 256'(1));
    check("reset_pulses", 256'({frame_done, frame_err}), 256'(0));

    // Frame 1 with swap_ok held high
    swap_ok = 1'b1;
    base_done = n_done; base_busy = n_busy;
    for (int k = 0; k < FRAME_BYTES; k++) send_byte(pat(k), k == 0);
    @(negedge clock);
    check("f1_pend_ready", 256'(in_ready), 256'(0));
    check("f1_no_done_yet", 256'(frame_done), 256'(0));
    @(negedge clock);
    check("f1_done", 256'(frame_done), 256'(1));
    check("f1_mat_0_15", 256'(mat[0:15]), 256'(16'h2040));
    check("f1_mat", 256'(mat), 256'(exp1));
    @(negedge clock);
    check("f1_done_once", 256'(n_done - base_done), 256'(1));
    check("f1_busy_1cyc", 256'(n_busy - base_busy), 256'(1));

    // Frame 2 held in PEND for 50 cycles
    swap_ok = 1'b0;
    base_done = n_done;
    for (int k = 0; k < FRAME_BYTES; k++) send_byte(~pat(k), k == 0);
    base_busy = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (in_ready !== 1'b0 || mat !== exp1) base_busy++;
    end
    check("f2_hold_bad_cyc", 256'(base_busy), 256'(0));
    check("f2_no_done_hold", 256'(n_done - base_done), 256'(0));
    swap_ok = 1'b1;
    @(negedge clock);
    check("f2_done", 256'(frame_done), 256'(1));
    check("f2_mat", 256'(mat), 256'(exp2));

    // Resync after 10 bytes
    base_err = n_err; base_done = n_done;
    for (int k = 0; k < 10; k++) send_byte(8'h55, k == 0);
    send_byte(8'hFF, 1'b1);
    for (int k = 1; k < FRAME_BYTES; k++) send_byte(8'h00, 1'b0);
    repeat (2) @(negedge clock);
    check("rs_err_once", 256'(n_err - base_err), 256'(1));
    check("rs_done_once", 256'(n_done - base_done), 256'(1));
    check("rs_mat_0_7", 256'(mat[0:7]), 256'(8'hFF));
    check("rs_mat_rest", 256'(mat[8:MAT_BITS-1]), 256'(0));

    // Stray bytes in IDLE are dropped
    base_err = n_err; base_done = n_done;
    for (int i = 0; i < 5; i++) send_byte(8'hAA, 1'b0);
    for (int k = 0; k < FRAME_BYTES; k++) send_byte(8'(k), k == 0);
    repeat (2) @(negedge clock);
    check("drop_mat", 256'(mat), 256'(exp3));
    check("drop_no_err", 256'(n_err - base_err), 256'(0));
    check("drop_done_once", 256'(n_done - base_done), 256'(1));

`ifdef FRAME_LOADER_TIMEOUT_EN
    // Partial frame aborted after 8 idle cycles
    base_err = n_err;
    first_err = 0;
    for (int k = 0; k < 5; k++) send_byte(8'hC3, k == 0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (frame_err === 1'b1 && first_err == 0) first_err = i;
    end
    check("to_err_cycle", 256'(first_err), 256'(9));
    check("to_err_once", 256'(n_err - base_err), 256'(1));
    check("to_mat_kept", 256'(mat), 256'(exp3));
    check("to_idle_ready", 256'(in_ready), 256'(1));
    for (int k = 0; k < FRAME_BYTES; k++) send_byte(8'(255 - k), k == 0);
    repeat (2) @(negedge clock);
    check("to_next_frame", 256'(mat), 256'(exp4));
`else
    first_err = 0;
    frame = exp4;
`endif

    // Reset while in PEND
    swap_ok = 1'b0;
    for (int k = 0; k < FRAME_BYTES; k++) send_byte(8'h3C, k == 0);
    @(negedge clock);
    check("rp_in_pend", 256'(in_ready), 256'(0));
    base_done = n_done;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    swap_ok = 1'b1;
    check("rp_mat_zero", 256'(mat), 256'(0));
    check("rp_idle_ready", 256'(in_ready), 256'(1));
    repeat (4) @(negedge clock);
    check("rp_no_done", 256'(n_done - base_done), 256'(0));
    check("rp_mat_still_0", 256'(mat), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1, "bench time limit reached");
  end

endmodule
